// File: rtl/mem_req_ctrl.sv
// Request controller in front of a 1-cycle-latency memory: post-reset scrub, request issue
// with credit-based flow control, and a 2-entry in-order read response FIFO.
module mem_req_ctrl #(
  parameter int unsigned        ADDR_W   = 3,
  parameter int unsigned        DATA_W   = 8,
  parameter bit                 INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VAL = 8'hCA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [0:1];
  logic [DATA_W-1:0] fifo_d [0:1];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic       run;
  logic       acc;
  logic       push;
  logic       pop;
  logic [2:0] credit;

  assign run       = (state_q == StRun);
  assign init_done = run && reset;
  assign rsp_valid = (occ_q != 2'd0);
  assign rsp_rdata = fifo_q[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready;
  assign push      = inflight_q;

  // Outstanding slots: entries held plus the read in flight, less the one leaving this cycle.
  assign credit    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign req_ready = run && reset && (credit < 3'd2);
  assign acc       = req_valid && req_ready;

  // Strobes are gated by the reset input so the memory sees nothing while reset is held.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (state_q == StInit) begin
        mem_wr_en = 1'b1;
        mem_addr  = init_ptr_q;
        mem_wdata = INIT_VAL;
      end else if (acc) begin
        mem_wr_en = req_write;
        mem_rd_en = !req_write;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == StInit) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == {ADDR_W{1'b1}}) begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    inflight_d = mem_rd_en;
    fifo_d[0]  = fifo_q[0];
    fifo_d[1]  = fifo_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT_EN ? StInit : StRun;
      init_ptr_q <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      inflight_q <= inflight_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && occ_q == 2'd2));
  a_no_dual_strobe: assert property (@(posedge clk) disable iff (!reset)
    !(mem_wr_en && mem_rd_en));
  a_rsp_stable: assert property (@(posedge clk) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=> $stable(rsp_rdata));
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: behavioural 8x8 memory, reference contents and a queue of
// expected read responses popped as the controller delivers them.
module tb_mem_req_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata)
  );

  // Memory with registered read data, one cycle after rd_en.
  logic [7:0] mem_model [8];
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem_model[mem_addr];
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [8];
  logic [7:0] exp_q [$];
  int         cyc = 0;
  int         rsp_cnt = 0;
  int         first_rsp = -1;
  int         last_rsp = -1;
  int         accepted;

  logic       s_req_ready, s_acc, s_rsp_valid, s_wr, s_rd, s_init_done;
  logic [7:0] s_rsp_rdata, s_wdata;
  logic [2:0] s_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with this cycle's inputs already driven.
  task automatic step();
    #1;
    s_req_ready = req_ready;
    s_acc       = req_valid && req_ready;
    s_rsp_valid = rsp_valid;
    s_rsp_rdata = rsp_rdata;
    s_wr        = mem_wr_en;
    s_rd        = mem_rd_en;
    s_addr      = mem_addr;
    s_wdata     = mem_wdata;
    s_init_done = init_done;
    if (s_acc && req_write) ref_mem[req_addr] = req_wdata;
    if (s_acc && !req_write) exp_q.push_back(ref_mem[req_addr]);
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (first_rsp < 0) first_rsp = cyc;
      last_rsp = cyc;
      chk("rsp_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rsp_data", rsp_rdata, exp_q.pop_front());
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic scrub_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      step();
      chk({tag, "_wr"}, s_wr, 1);
      chk({tag, "_rd"}, s_rd, 0);
      chk({tag, "_addr"}, s_addr, i);
      chk({tag, "_wdata"}, s_wdata, 8'hCA);
      chk({tag, "_ready"}, s_req_ready, 0);
      chk({tag, "_done"}, s_init_done, 0);
      chk({tag, "_rspv"}, s_rsp_valid, 0);
    end
    step();
    chk({tag, "_init_done"}, s_init_done, 1);
    chk({tag, "_req_ready"}, s_req_ready, 1);
    chk({tag, "_post_wr"}, s_wr, 0);
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'hCA;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_req_ready", s_req_ready, 0);
    chk("rst_rsp_valid", s_rsp_valid, 0);
    chk("rst_rsp_rdata", s_rsp_rdata, 0);
    chk("rst_init_done", s_init_done, 0);
    chk("rst_mem_wr", s_wr, 0);
    chk("rst_mem_rd", s_rd, 0);
    chk("rst_mem_addr", s_addr, 0);
    chk("rst_mem_wdata", s_wdata, 0);

    // 1: scrub after release
    reset = 1'b1;
    scrub_check("scrub");

    // 2: read after scrub, two-cycle response latency
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd3;
    step();
    chk("t2_acc", s_acc, 1);
    chk("t2_rd_en", s_rd, 1);
    chk("t2_addr", s_addr, 3);
    req_valid = 1'b0;
    step();
    chk("t2_rsp_early", s_rsp_valid, 0);
    step();
    chk("t2_rsp_valid", s_rsp_valid, 1);
    chk("t2_rsp_rdata", s_rsp_rdata, 8'hCA);

    // 3: write then read-after-write on the next cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 8'h5A;
    step();
    chk("t3_wr", s_wr, 1);
    chk("t3_wdata", s_wdata, 8'h5A);
    req_write = 1'b0;
    step();
    chk("t3_rd", s_rd, 1);
    req_valid = 1'b0;
    step();
    step();
    chk("t3_drained", exp_q.size(), 0);

    // 4: backpressure with reads to 0..3 holding distinct data
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 3'(i); req_wdata = 8'h10 + 8'(i);
      step();
      chk("t4_wr_acc", s_acc, 1);
    end
    req_write = 1'b0;
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = (accepted < 4);
      req_addr  = 3'(accepted);
      step();
      if (s_acc) accepted++;
      if (s_rsp_valid) chk("t4_head_held", s_rsp_rdata, 8'h10);
    end
    chk("t4_accepted", accepted, 2);
    chk("t4_ready_low", s_req_ready, 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      req_valid = (accepted < 4);
      req_addr  = 3'(accepted);
      step();
      if (s_acc) accepted++;
      if (accepted == 4 && exp_q.size() == 0 && !rsp_valid) break;
    end
    req_valid = 1'b0;
    chk("t4_accepted_all", accepted, 4);
    chk("t4_drained", exp_q.size(), 0);

    // 5: sustained one read per cycle
    rsp_cnt = 0; first_rsp = -1; last_rsp = -1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 3'(i);
      step();
      chk("t5_ready", s_req_ready, 1);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("t5_count", rsp_cnt, 8);
    chk("t5_consecutive", last_rsp - first_rsp, 7);

    // 6: reset with a response held and a read in flight
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 3'd6;
    step();
    req_addr = 3'd7;
    step();
    req_valid = 1'b0;
    #1;
    chk("t6_pre_valid", rsp_valid, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_rdata", rsp_rdata, 0);
    chk("t6_rst_ready", req_ready, 0);
    exp_q.delete();
    @(negedge clk);
    step();
    rsp_ready = 1'b1;
    reset = 1'b1;
    scrub_check("rescrub");
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6_no_stale", s_rsp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
